// File: rtl/comparator_scheduler.sv
// comparator_scheduler
//   Shares one chunk-serial magnitude comparator between two requesters
//   (req0: branch-resolve unit, req1: slt/sltu unit). A round-robin arbiter
//   picks a winner in IDLE and latches its operands. The operands are then
//   walked MSB chunk first, stopping at the first unequal chunk. The result
//   goes back to the granted requester with a one-cycle done pulse.
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req0/a0/b0/sgn0   requester 0 request level, operands, signed select
//   req1/a1/b1/sgn1   requester 1 request level, operands, signed select
//   gnt0/gnt1         one-cycle pulse: that requester's operands were captured
//   done0/done1       one-cycle pulse: result valid for that requester
//   outgt/outeq/outlt one-hot compare result, held until the next done
//   busy              high in every non-IDLE state
module comparator_scheduler #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             sgn0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sgn1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             outgt,
  output logic             outeq,
  output logic             outlt,
  output logic             busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             rr_ptr;
  logic             id;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  logic             win;
  logic [WIDTH-1:0] wa;
  logic [WIDTH-1:0] wb;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;

  // Winner: a lone requester always wins; rr_ptr only breaks ties.
  // Signed operands get their MSB inverted so the unsigned chunk walk
  // yields two's-complement ordering.
  always_comb begin
    win = req1 & (~req0 | rr_ptr);
    wa  = win ? a1 : a0;
    wb  = win ? b1 : b0;
    if (win ? sgn1 : sgn0) begin
      wa[WIDTH-1] = ~wa[WIDTH-1];
      wb[WIDTH-1] = ~wb[WIDTH-1];
    end
  end

  always_comb begin
    ca = opa[idx*CHUNK +: CHUNK];
    cb = opb[idx*CHUNK +: CHUNK];
  end

  // done and the result flags are loaded on the CMP->DONE transition so
  // they are visible during the DONE cycle itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      id     <= 1'b0;
      idx    <= IW'(NCHUNK - 1);
      opa    <= '0;
      opb    <= '0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      outgt  <= 1'b0;
      outeq  <= 1'b0;
      outlt  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            id    <= win;
            opa   <= wa;
            opb   <= wb;
            gnt0  <= ~win;
            gnt1  <= win;
            idx   <= IW'(NCHUNK - 1);
            busy  <= 1'b1;
            state <= CMP;
          end
        end
        CMP: begin
          if (ca != cb) begin
            outgt <= (ca > cb);
            outlt <= (ca < cb);
            outeq <= 1'b0;
            done0 <= ~id;
            done1 <= id;
            state <= DONE;
          end else if (idx == '0) begin
            outgt <= 1'b0;
            outlt <= 1'b0;
            outeq <= 1'b1;
            done0 <= ~id;
            done1 <= id;
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          rr_ptr <= ~id;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_scheduler.sv
module tb_comparator_scheduler;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1, sgn0, sgn1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             gnt0, gnt1, done0, done1;
  logic             outgt, outeq, outlt, busy;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2:0] prev_res;   // {gt,eq,lt} expected to be held on the outputs

  always #5 clk = ~clk;

  comparator_scheduler #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .sgn0(sgn0),
    .req1(req1), .a1(a1), .b1(b1), .sgn1(sgn1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .outgt(outgt), .outeq(outeq), .outlt(outlt), .busy(busy)
  );

  // Reference: plain signed/unsigned comparison.
  function automatic logic [2:0] ref_res(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic s);
    if (s) begin
      if ($signed(a) > $signed(b)) return 3'b100;
      if ($signed(a) < $signed(b)) return 3'b001;
      return 3'b010;
    end
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    return 3'b010;
  endfunction

  // Reference latency (cycles from request cycle to done cycle): one grant
  // cycle plus one cycle per chunk examined down to the highest differing bit.
  function automatic int ref_lat(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    int top;
    d = a ^ b;
    top = -1;
    for (int i = 0; i < WIDTH; i++) if (d[i]) top = i;
    if (top < 0) return 1 + NCHUNK;
    return 1 + NCHUNK - top / CHUNK;
  endfunction

  // Called at posedge+1 of an IDLE cycle with no request pending; returns
  // at posedge+1 of the IDLE cycle following the done cycle.
  task automatic do_op(input int r, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic s,
                       input string name);
    logic [2:0] exp;
    int el, lat;
    exp = ref_res(a, b, s);
    el  = ref_lat(a, b);
    if (r == 0) begin a0 = a; b0 = b; sgn0 = s; req0 = 1'b1; end
    else        begin a1 = a; b1 = b; sgn1 = s; req1 = 1'b1; end
    @(posedge clk); #1;
    n_cmp++;
    if ({gnt0, gnt1, busy} !== {r == 0, r == 1, 1'b1}) begin
      n_fail++;
      $display("FAIL %s grant: got gnt0/gnt1/busy=%b%b%b want %b%b1",
               name, gnt0, gnt1, busy, r == 0, r == 1);
    end
    n_cmp++;
    if ({outgt, outeq, outlt} !== prev_res) begin
      n_fail++;
      $display("FAIL %s held_result: got %b want %b", name,
               {outgt, outeq, outlt}, prev_res);
    end
    // Operands only need to be valid in the grant cycle.
    if (r == 0) begin a0 = $urandom; b0 = $urandom; sgn0 = ~s; end
    else        begin a1 = $urandom; b1 = $urandom; sgn1 = ~s; end
    lat = 0;
    for (int c = 2; c <= 12; c++) begin
      @(posedge clk); #1;
      if (done0 || done1) begin lat = c; break; end
    end
    n_cmp++;
    if (lat != el) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d (0 = timeout)", name, lat, el);
    end
    if (lat != 0) begin
      n_cmp++;
      if ({done0, done1, outgt, outeq, outlt} !== {r == 0, r == 1, exp}) begin
        n_fail++;
        $display("FAIL %s result: got done=%b%b gt/eq/lt=%b want done=%b%b gt/eq/lt=%b",
                 name, done0, done1, {outgt, outeq, outlt}, r == 0, r == 1, exp);
      end
      prev_res = exp;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({done0, done1, gnt0, gnt1, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL %s idle_after: got done/gnt/busy=%b want 00000", name,
               {done0, done1, gnt0, gnt1, busy});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; sgn0 = 1'b0; sgn1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, gnt0, gnt1, done0, done1, outgt, outeq, outlt} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {busy, gnt0, gnt1, done0, done1, outgt, outeq, outlt});
    end
    reset = 1'b0;
    prev_res = 3'b000;
  endtask

  task automatic test_directed();
    do_op(0, 32'h12345678, 32'h12345679, 1'b0, "t2_lsb_lt");
    do_op(1, 32'h80000000, 32'h00000001, 1'b0, "t3_unsigned_gt");
    do_op(1, 32'h80000000, 32'h00000001, 1'b1, "t3_signed_lt");
    do_op(0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "t4_equal");
    do_op(0, 32'hFFFFFFFF, 32'h00000000, 1'b1, "t4_signed_neg");
    do_op(1, 32'h7FFFFFFF, 32'h80000000, 1'b1, "signed_max_min");
    do_op(1, 32'h12345678, 32'h12345678, 1'b1, "signed_equal");
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    logic [63:0] m;
    int k;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = $urandom;
      k = $urandom_range(0, NCHUNK);
      // Copy the top k chunks so early-exit depth varies.
      m = ((64'd1 << (CHUNK * k)) - 64'd1) << (WIDTH - CHUNK * k);
      b = (b & ~m[WIDTH-1:0]) | (a & m[WIDTH-1:0]);
      do_op($urandom_range(0, 1), a, b, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  // Both requesters held high from reset; each drops in its done cycle and
  // re-raises in the following IDLE cycle. Grants must alternate from 0.
  task automatic test_back_to_back();
    logic [2:0] exp;
    int el, lat, w;
    reset = 1'b1;
    a0 = $urandom; b0 = $urandom; sgn0 = 1'($urandom_range(0, 1));
    a1 = $urandom; b1 = $urandom; sgn1 = 1'($urandom_range(0, 1));
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    prev_res = 3'b000;
    for (int k = 0; k < 4; k++) begin
      w = k % 2;
      exp = (w == 0) ? ref_res(a0, b0, sgn0) : ref_res(a1, b1, sgn1);
      el  = (w == 0) ? ref_lat(a0, b0) : ref_lat(a1, b1);
      @(posedge clk); #1;
      n_cmp++;
      if ({gnt0, gnt1} !== {w == 0, w == 1}) begin
        n_fail++;
        $display("FAIL fair_grant%0d: got gnt0/gnt1=%b%b want %b%b", k,
                 gnt0, gnt1, w == 0, w == 1);
      end
      lat = 0;
      for (int c = 2; c <= 12; c++) begin
        @(posedge clk); #1;
        if (done0 || done1) begin lat = c; break; end
      end
      n_cmp++;
      if (lat != el) begin
        n_fail++;
        $display("FAIL fair_latency%0d: got %0d want %0d (0 = timeout)", k, lat, el);
      end
      n_cmp++;
      if ({done0, done1, outgt, outeq, outlt} !== {w == 0, w == 1, exp}) begin
        n_fail++;
        $display("FAIL fair_result%0d: got done=%b%b gt/eq/lt=%b want done=%b%b gt/eq/lt=%b",
                 k, done0, done1, {outgt, outeq, outlt}, w == 0, w == 1, exp);
      end
      prev_res = exp;
      if (w == 0) req0 = 1'b0; else req1 = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({done0, done1, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL fair_idle%0d: got done/busy=%b want 000", k,
                 {done0, done1, busy});
      end
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end else if (w == 0) begin
        a0 = $urandom; b0 = $urandom; sgn0 = 1'($urandom_range(0, 1)); req0 = 1'b1;
      end else begin
        a1 = $urandom; b1 = $urandom; sgn1 = 1'($urandom_range(0, 1)); req1 = 1'b1;
      end
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    a0 = 32'hCAFEF00D; b0 = 32'hCAFEF00D; sgn0 = 1'b0; req0 = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({gnt0, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL abort_grant: got gnt0/busy=%b%b want 11", gnt0, busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done0, done1} !== 3'b100) begin
      n_fail++;
      $display("FAIL abort_cmp2: got busy/done=%b want 100", {busy, done0, done1});
    end
    reset = 1'b1;
    req0 = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, gnt0, gnt1, done0, done1, outgt, outeq, outlt} !== 8'b0) begin
      n_fail++;
      $display("FAIL abort_after_reset: got %b want 00000000",
               {busy, gnt0, gnt1, done0, done1, outgt, outeq, outlt});
    end
    reset = 1'b0;
    prev_res = 3'b000;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done0 || done1 || busy) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d active cycles want 0", seen);
    end
    do_op(0, 32'h00000005, 32'h00000003, 1'b0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
